// File: rtl/window_fetch_pkg.sv
// Shared types and constants for the SAD window fetch controller.
package window_fetch_pkg;

    localparam int WIN_DIM    = 4;
    localparam int WIN_WORDS  = WIN_DIM * WIN_DIM;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_ABORT
    } fetch_state_e;

    // Row-major position inside the 4x4 window.
    function automatic logic [3:0] word_index(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/window_fetch_ctrl_if.sv
// Single-word read port between the window fetcher and data memory.
interface window_fetch_ctrl_if;
    logic [31:0] MemAddr;
    logic        MemRead;
    logic [31:0] MemReadData;
    logic        MemReadValid;

    modport master (
        output MemAddr,
        output MemRead,
        input  MemReadData,
        input  MemReadValid
    );

    modport slave (
        input  MemAddr,
        input  MemRead,
        output MemReadData,
        output MemReadValid
    );
endinterface

// File: rtl/window_addr_gen.sv
// Row/column walker over a 4x4 window of a row-major frame; produces the
// byte address of the current word.
module window_addr_gen
    import window_fetch_pkg::*;
#(
    parameter int FRAME_WIDTH = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load_i,
    input  logic [31:0] base_i,
    input  logic        advance_i,
    output logic [31:0] addr_o,
    output logic [3:0]  word_idx_o,
    output logic        last_o
);

    logic [31:0] base_q, base_d;
    logic [1:0]  row_q, row_d;
    logic [1:0]  col_q, col_d;
    logic [31:0] word_off;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            base_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            base_q <= base_d;
            row_q  <= row_d;
            col_q  <= col_d;
        end
    end

    always_comb begin
        base_d = base_q;
        row_d  = row_q;
        col_d  = col_q;
        if (load_i) begin
            base_d = {base_i[31:2], 2'b00};
            row_d  = '0;
            col_d  = '0;
        end else if (advance_i) begin
            // 2-bit column wraps 3 -> 0 on its own; row follows the wrap.
            col_d = col_q + 2'd1;
            if (col_q == 2'(WIN_DIM - 1)) begin
                row_d = row_q + 2'd1;
            end
        end
    end

    assign word_off   = 32'(row_q) * 32'(FRAME_WIDTH) + 32'(col_q);
    assign addr_o     = base_q + word_off * 32'(WORD_BYTES);
    assign word_idx_o = word_index(row_q, col_q);
    assign last_o     = (row_q == 2'(WIN_DIM - 1)) && (col_q == 2'(WIN_DIM - 1));

endmodule

// File: rtl/window_fetch_ctrl.sv
// Sequential 4x4 window fetcher for the SAD unit: one outstanding read per word.
// Optional per-word timeout abort enabled by WINDOW_FETCH_TIMEOUT_EN.
module window_fetch_ctrl
    import window_fetch_pkg::*;
#(
    parameter int FRAME_WIDTH    = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [31:0]          BaseAddr,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error,
    window_fetch_ctrl_if.master  mem,
    output logic [31:0]          V1,
    output logic [31:0]          V2,
    output logic [31:0]          V3,
    output logic [31:0]          V4,
    output logic [31:0]          V5,
    output logic [31:0]          V6,
    output logic [31:0]          V7,
    output logic [31:0]          V8,
    output logic [31:0]          V9,
    output logic [31:0]          V10,
    output logic [31:0]          V11,
    output logic [31:0]          V12,
    output logic [31:0]          V13,
    output logic [31:0]          V14,
    output logic [31:0]          V15,
    output logic [31:0]          V16
);

    if (FRAME_WIDTH < WIN_DIM || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("window_fetch_ctrl: FRAME_WIDTH must be >= 4 and TIMEOUT_CYCLES >= 1");
    end

    fetch_state_e state_q, state_d;
    logic         load, advance, capture, mem_read, done;
    logic [31:0]  addr;
    logic [3:0]   word_idx;
    logic         last;
    logic [31:0]  v_q [WIN_WORDS];

    window_addr_gen #(.FRAME_WIDTH(FRAME_WIDTH)) u_addr_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_i     (load),
        .base_i     (BaseAddr),
        .advance_i  (advance),
        .addr_o     (addr),
        .word_idx_o (word_idx),
        .last_o     (last)
    );

`ifdef WINDOW_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          err;

    // Down-counter reloaded on every request; terminal count means the word is lost.
    always_comb begin
        timer_d = timer_q;
        if (state_q == ST_REQ) begin
            timer_d = TW'(TIMEOUT_CYCLES - 1);
        end else if (state_q == ST_WAIT && timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        advance  = 1'b0;
        capture  = 1'b0;
        mem_read = 1'b0;
        done     = 1'b0;
`ifdef WINDOW_FETCH_TIMEOUT_EN
        err      = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    load    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_read = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem.MemReadValid) begin
                    capture = 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = ST_REQ;
                    end
                end
`ifdef WINDOW_FETCH_TIMEOUT_EN
                else if (timer_q == '0) begin
                    state_d = ST_ABORT;
                end
`endif
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef WINDOW_FETCH_TIMEOUT_EN
            ST_ABORT: begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < WIN_WORDS; i++) v_q[i] <= '0;
        end else if (capture) begin
            v_q[word_idx] <= mem.MemReadData;
        end
    end

    assign Busy        = (state_q != ST_IDLE);
    assign Done        = done;
`ifdef WINDOW_FETCH_TIMEOUT_EN
    assign Error       = err;
`else
    assign Error       = 1'b0;
`endif
    assign mem.MemRead = mem_read;
    assign mem.MemAddr = mem_read ? addr : '0;

    assign V1  = v_q[0];
    assign V2  = v_q[1];
    assign V3  = v_q[2];
    assign V4  = v_q[3];
    assign V5  = v_q[4];
    assign V6  = v_q[5];
    assign V7  = v_q[6];
    assign V8  = v_q[7];
    assign V9  = v_q[8];
    assign V10 = v_q[9];
    assign V11 = v_q[10];
    assign V12 = v_q[11];
    assign V13 = v_q[12];
    assign V14 = v_q[13];
    assign V15 = v_q[14];
    assign V16 = v_q[15];

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Directed bench for window_fetch_ctrl with a cycle-stepped read responder.
module tb_window_fetch_ctrl;

    logic        Clk      = 1'b0;
    logic        Reset    = 1'b0;
    logic        Start    = 1'b0;
    logic [31:0] BaseAddr = '0;
    wire         Busy, Done, Error;
    wire  [31:0] v [16];

    window_fetch_ctrl_if mem_if ();

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] req_addr [16];
    int          n_req, done_cyc, err_cyc, busy_cnt;
    logic        saw_read;

    always #5 Clk = ~Clk;

    window_fetch_ctrl #(.FRAME_WIDTH(64), .TIMEOUT_CYCLES(8)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .BaseAddr (BaseAddr),
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error),
        .mem      (mem_if.master),
        .V1  (v[0]),  .V2  (v[1]),  .V3  (v[2]),  .V4  (v[3]),
        .V5  (v[4]),  .V6  (v[5]),  .V7  (v[6]),  .V8  (v[7]),
        .V9  (v[8]),  .V10 (v[9]),  .V11 (v[10]), .V12 (v[11]),
        .V13 (v[12]), .V14 (v[13]), .V15 (v[14]), .V16 (v[15])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
        return (base & ~32'h3) + 32'(4 * ((k / 4) * 64 + (k % 4)));
    endfunction

    // Cycle 0 presents Start; responder returns MemAddr^key lat cycles after each
    // MemRead. stall_req drops that request; start_cyc re-pulses Start; rst_cyc
    // pulls Reset low for one edge and returns.
    task automatic run_fetch(input logic [31:0] base, input int lat, input bit spurious,
                             input logic [31:0] key, input int stall_req,
                             input int start_cyc, input int rst_cyc);
        int          cyc;
        int          pend;
        logic [31:0] paddr;
        n_req = 0; done_cyc = -1; err_cyc = -1; busy_cnt = 0; pend = 0; paddr = '0;
        mem_if.MemReadValid = 1'b0;
        Start = 1'b1;
        BaseAddr = base;
        tick();
        Start = 1'b0;
        BaseAddr = 32'hDEAD_BEE0;
        cyc = 1;
        while (cyc < 300) begin
            mem_if.MemReadValid = 1'b0;
            mem_if.MemReadData  = 32'h0BAD_F00D;
            Start = (cyc == start_cyc);
            if (cyc == start_cyc) BaseAddr = 32'h0008_0000;
            if (Busy) busy_cnt++;
            if (Done) begin
                done_cyc = cyc;
                break;
            end
            if (Error) begin
                err_cyc = cyc;
                break;
            end
            if (mem_if.MemRead) begin
                if (n_req < 16) req_addr[n_req] = mem_if.MemAddr;
                if (n_req != stall_req) begin
                    pend  = lat;
                    paddr = mem_if.MemAddr;
                end
                n_req++;
                if (spurious) mem_if.MemReadValid = 1'b1;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_if.MemReadValid = 1'b1;
                    mem_if.MemReadData  = paddr ^ key;
                end
            end
            if (cyc == rst_cyc) begin
                Reset = 1'b0;
                tick();
                Reset = 1'b1;
                mem_if.MemReadValid = 1'b0;
                break;
            end
            tick();
            cyc++;
        end
        Start = 1'b0;
        mem_if.MemReadValid = 1'b0;
    endtask

    initial begin
        mem_if.MemReadValid = 1'b0;
        mem_if.MemReadData  = '0;
        Reset = 1'b0;
        repeat (3) tick();
        chk("rst_busy",    32'(Busy), 0);
        chk("rst_done",    32'(Done), 0);
        chk("rst_error",   32'(Error), 0);
        chk("rst_memread", 32'(mem_if.MemRead), 0);
        chk("rst_memaddr", mem_if.MemAddr, 0);
        chk("rst_v1",      v[0], 0);
        chk("rst_v16",     v[15], 0);
        Reset = 1'b1;

        saw_read = 1'b0;
        repeat (10) begin
            tick();
            if (mem_if.MemRead || Busy) saw_read = 1'b1;
        end
        chk("idle_no_read", 32'(saw_read), 0);

        // 1-cycle responder, data = address
        run_fetch(32'h100, 1, 1'b0, 32'h0, -1, -1, -1);
        chk("A_done_cyc", 32'(done_cyc), 33);
        chk("A_busy_cnt", 32'(busy_cnt), 33);
        chk("A_nreq",     32'(n_req), 16);
        chk("A_no_error", 32'(err_cyc), 32'hFFFF_FFFF);
        chk("A_addr4",    req_addr[4], 32'h200);
        chk("A_v16",      v[15], 32'h40C);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("A_addr%0d", k), req_addr[k], exp_addr(32'h100, k));
            chk($sformatf("A_v%0d", k + 1), v[k], exp_addr(32'h100, k));
        end
        tick();
        chk("A_idle_busy", 32'(Busy), 0);
        chk("A_idle_done", 32'(Done), 0);

        // 3-cycle responder, unaligned base, spurious valid during REQ
        run_fetch(32'h103, 3, 1'b1, 32'hA5A5_0000, -1, -1, -1);
        chk("B_done_cyc", 32'(done_cyc), 65);
        chk("B_busy_cnt", 32'(busy_cnt), 65);
        chk("B_addr0",    req_addr[0], 32'h100);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("B_v%0d", k + 1), v[k], exp_addr(32'h100, k) ^ 32'hA5A5_0000);
        end
        tick();

        // Start re-pulsed at cycle 10, reset at cycle 12 with a valid word pending
        run_fetch(32'h3000, 1, 1'b0, 32'h1111_0000, -1, 10, 12);
        chk("C_nreq",    32'(n_req), 6);
        chk("C_addr5",   req_addr[5], exp_addr(32'h3000, 5));
        chk("C_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        chk("C_busy",    32'(Busy), 0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("C_v%0d", k + 1), v[k], 0);
        end

        run_fetch(32'h100, 1, 1'b0, 32'h5A5A_0000, -1, -1, -1);
        chk("D_done_cyc", 32'(done_cyc), 33);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("D_v%0d", k + 1), v[k], exp_addr(32'h100, k) ^ 32'h5A5A_0000);
        end
        tick();

`ifdef WINDOW_FETCH_TIMEOUT_EN
        // responder drops the sixth request; abort after 8 idle WAIT cycles
        run_fetch(32'h800, 1, 1'b0, 32'h7777_0000, 5, -1, -1);
        chk("E_err_cyc", 32'(err_cyc), 20);
        chk("E_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("E_v%0d", k + 1), v[k], exp_addr(32'h800, k) ^ 32'h7777_0000);
        end
        for (int k = 5; k < 16; k++) begin
            chk($sformatf("E_v%0d", k + 1), v[k], exp_addr(32'h100, k) ^ 32'h5A5A_0000);
        end
        tick();
        chk("E_err_pulse", 32'(Error), 0);
        chk("E_idle",      32'(Busy), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_fetch_ctrl.md
# window_fetch_ctrl

Memory-stage read initiator for the SAD datapath: on `Start` it issues 16 single-word reads to the data memory read port, walking a 4x4 window of a row-major frame, and captures each returned word into outputs `V1`..`V16` for the SAD unit. It is the requesting end of the data memory's read interface, replacing bulk window exposure with a sequential fetch.

## Interface
- `FRAME_WIDTH`, 64, frame row length in 32-bit words (power of two not required, ≥4)
- `TIMEOUT_CYCLES`, 255, per-word wait limit (used only with the timeout feature)
- `Clk` in 1: single clock, rising edge
- `Reset` in 1: reset, synchronous, active-low
- `Start` in 1: begin fetch; sampled only in IDLE
- `BaseAddr` in 32: byte address of window top-left word; bits [1:0] ignored (forced 0)
- `Busy` out 1: high from the cycle after an accepted `Start` until `Done` completes
- `Done` out 1: one-cycle pulse after the 16th word is captured
- `Error` out 1: one-cycle pulse on timeout abort; constant 0 without the timeout feature
- `MemAddr` out 32: word-aligned read address
- `MemRead` out 1: read request strobe, exactly one cycle per word
- `MemReadData` in 32: returned word
- `MemReadValid` in 1: `MemReadData` valid this cycle
- `V1`..`V16` out 32 each: window words, row-major (`V1`=row0/col0, `V4`=row0/col3, `V5`=row1/col0, `V16`=row3/col3)

## Operation
- States: IDLE, REQ, WAIT, DONE (plus ABORT with timeout feature).
- IDLE: `Start`=1 → latch `BaseAddr & ~3`, clear row/col counters, go REQ. Otherwise stay.
- REQ: `MemRead`=1, `MemAddr` = base + 4*(row*FRAME_WIDTH + col); go WAIT unconditionally.
- WAIT: `MemRead`=0; on `MemReadValid` write `MemReadData` to `V[row*4+col+1]`; if word 15 → DONE, else advance col (col 3 wraps to 0, row+1) and → REQ.
- DONE: `Done`=1 for one cycle, → IDLE.
- One outstanding read only; `MemReadValid` in IDLE, REQ or DONE ignored; valid in the same cycle as `MemRead` is not accepted.
- `Start` while not IDLE ignored; no restart mid-fetch.
- `V*` update individually as captured; retain values after `Done` until overwritten by the next fetch or reset.
- Address arithmetic 32-bit, wraps modulo 2^32 with no error.

## Timing
- Reset (`Reset`=0 at an edge): state IDLE, `Busy`=`Done`=`Error`=`MemRead`=0, `MemAddr`=0, all `V*`=0, counters 0. Dominates all other inputs, including mid-fetch.
- Start accepted at cycle 0 → `MemRead` for word k at cycle 2k+1 when responder returns valid the following cycle; word k captured at end of cycle 2k+2; `Done` high at cycle 33.
- Each extra responder wait cycle adds one cycle per word; no upper bound without timeout.
- `Busy` high cycles 1..33 inclusive (same as non-IDLE states).

## Configuration
- `WINDOW_FETCH_TIMEOUT_EN` defined: WAIT counts cycles; reaching `TIMEOUT_CYCLES` with no valid → ABORT: `Error`=1 one cycle, → IDLE, `V*` keep partial contents, no `Done`. Counter reset on each REQ.
- Undefined: no counter, WAIT indefinitely, `Error` tied 0.

## Structure
- Shared package/header `window_fetch_pkg`: state encodings, `WIN_DIM`=4, `WIN_WORDS`=16, word byte stride 4.
- One sub-module: `window_addr_gen` — row/col counters, wrap, and address computation; FSM and capture registers in top.

## Test plan
- Reset then idle: all outputs 0, `MemRead` never asserts with `Start`=0.
- `BaseAddr`=0x100, FRAME_WIDTH=64, 1-cycle responder returning address as data → addresses 0x100,0x104,0x108,0x10C,0x200,...,0x40C; `V16`=0x40C; `Done` at cycle 33.
- Responder with 3-cycle latency, `BaseAddr`=0x103 → first `MemAddr`=0x100; `Done` at cycle 65; spurious `MemReadValid` during REQ ignored.
- `Start` pulsed at cycle 10 mid-fetch → ignored; `Reset`=0 at cycle 12 → IDLE, all `V*` 0, next fetch completes normally.
- With `WINDOW_FETCH_TIMEOUT_EN`, TIMEOUT_CYCLES=8, responder stalls on word 5 → `Error` pulse, `V1`..`V5` valid, `V6`..`V16` unchanged, no `Done`.
